// File: rtl/seg7_scan_driver_if.sv
// Display-stage bus for seg7_scan_driver: result-word capture on the input side,
// multiplexed seven-segment drive and frame status on the output side.
interface seg7_scan_driver_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic [7:0]  digit_en;
  logic [6:0]  seg;
  logic [7:0]  ans;
  logic        frame_done;
  logic        pending;

  modport master (
    output data_in, data_valid, digit_en,
    input  seg, ans, frame_done, pending
  );

  modport slave (
    input  data_in, data_valid, digit_en,
    output seg, ans, frame_done, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Frame-synchronous 8-digit hex scanner for a common-anode seven-segment array.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input logic             clk,
  input logic             reset,
  seg7_scan_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic             pend_q, pend_d;
  logic [31:0]      disp_q, disp_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       ans_q, ans_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             boundary;
  logic [7:0]       show_mask;
  logic [3:0]       nibble;
  logic             lit;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k stays lit if any nibble at or above k is nonzero; digit 0 always lit.
  function automatic logic [7:0] lzb_mask(input logic [31:0] v);
    logic [7:0] m;
    logic       seen;
    m    = 8'h00;
    seen = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      seen = seen | (v[4*k +: 4] != 4'h0);
      m[k] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction
`else
  function automatic logic [7:0] lzb_mask(input logic [31:0] v);
    logic unused;
    unused = ^v;
    return 8'hFF;
  endfunction
`endif

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 3'd7);

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    disp_d      = disp_q;

    if (boundary) begin
      // A strobe landing on the boundary tick is newer than anything pending.
      if (bus.data_valid) disp_d = bus.data_in;
      else if (pend_q)    disp_d = pend_data_q;
      pend_d = 1'b0;
    end else if (bus.data_valid) begin
      pend_data_d = bus.data_in;
      pend_d      = 1'b1;
    end

    // Outputs are built from next-state so the drive lines up with the index register.
    show_mask    = bus.digit_en & lzb_mask(disp_d);
    nibble       = disp_d[{idx_d, 2'b00} +: 4];
    lit          = show_mask[idx_d];
    ans_d        = lit ? ~(8'b1 << idx_d) : 8'hFF;
    seg_d        = lit ? hex_decode(nibble) : 7'h7F;
    frame_done_d = boundary;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      pend_data_q  <= 32'h0;
      pend_q       <= 1'b0;
      disp_q       <= 32'h0;
      seg_q        <= 7'h7F;
      ans_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      ans_q        <= ans_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.ans        = ans_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver at SCAN_DIV=4, CNT_W=3.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_seg7_scan_driver;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_hex(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [31:0] v);
    logic [7:0] m;
    m = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 7; k >= 1; k--) begin
      if (v[4*k +: 4] != 4'h0) break;
      m[k] = 1'b0;
    end
`endif
    return m;
  endfunction

  // Advance at least one cycle, then until frame_done is seen (bounded).
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", {31'b0, bus.frame_done}, 32'd1);
  endtask

  // Starting on the frame_done cycle, check all 32 cycles of one frame.
  task automatic check_frame(input logic [31:0] val, input logic [7:0] en);
    logic [7:0] m;
    logic [7:0] one_hot;
    int         k;
    m = en & exp_mask(val);
    for (int i = 0; i < 32; i++) begin
      k = i / 4;
      one_hot = 8'h01 << k;
      if (m[k]) begin
        check($sformatf("seg d%0d", k), {25'b0, bus.seg}, {25'b0, exp_hex(val[4*k +: 4])});
        check($sformatf("ans d%0d", k), {24'b0, bus.ans}, {24'b0, ~one_hot});
      end else begin
        check($sformatf("seg dark d%0d", k), {25'b0, bus.seg}, 32'h7F);
        check($sformatf("ans dark d%0d", k), {24'b0, bus.ans}, 32'hFF);
      end
      @(negedge clk);
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    bus.data_in    = 32'h0;
    bus.data_valid = 1'b0;
    bus.digit_en   = 8'hFF;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst seg",        {25'b0, bus.seg},        32'h7F);
    check("rst ans",        {24'b0, bus.ans},        32'hFF);
    check("rst frame_done", {31'b0, bus.frame_done}, 32'h0);
    check("rst pending",    {31'b0, bus.pending},    32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("post rst seg", {25'b0, bus.seg}, 32'h40);
    check("post rst ans", {24'b0, bus.ans}, 32'hFE);

    // Full frame walk with display 0
    wait_frame();
    check_frame(32'h0, 8'hFF);

    // Mid-frame capture of 3
    repeat (5) @(negedge clk);
    strobe(32'h0000_0003);
    check("pending set", {31'b0, bus.pending}, 32'h1);
    repeat (10) @(negedge clk);
    check("pending held", {31'b0, bus.pending}, 32'h1);
    wait_frame();
    check("pending cleared", {31'b0, bus.pending}, 32'h0);
    check_frame(32'h0000_0003, 8'hFF);

    // Two strobes in one frame: last write wins
    repeat (2) @(negedge clk);
    strobe(32'h1111_1111);
    repeat (3) @(negedge clk);
    strobe(32'h2222_2222);
    wait_frame();
    check_frame(32'h2222_2222, 8'hFF);

    // Strobe on the boundary tick cycle (digit 7, last prescaler count)
    repeat (31) @(negedge clk);
`ifndef LEADING_ZERO_BLANK_EN
    check("digit7 before bnd", {24'b0, bus.ans}, 32'h7F);
`endif
    strobe(32'hFEDC_BA98);
    check("bnd frame_done", {31'b0, bus.frame_done}, 32'h1);
    check("bnd pending",    {31'b0, bus.pending},    32'h0);
    check_frame(32'hFEDC_BA98, 8'hFF);

    // digit_en masking
    bus.digit_en = 8'h0F;
    strobe(32'h1234_5678);
    check("en pending", {31'b0, bus.pending}, 32'h1);
    wait_frame();
    check("en committed", {31'b0, bus.pending}, 32'h0);
    check_frame(32'h1234_5678, 8'h0F);
    bus.digit_en = 8'hFF;

    // Asynchronous reset mid-frame with data pending
    repeat (5) @(negedge clk);
    strobe(32'hABCD_0123);
    check("pre rst pending", {31'b0, bus.pending}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async seg",        {25'b0, bus.seg},        32'h7F);
    check("async ans",        {24'b0, bus.ans},        32'hFF);
    check("async pending",    {31'b0, bus.pending},    32'h0);
    check("async frame_done", {31'b0, bus.frame_done}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rerst pending", {31'b0, bus.pending}, 32'h0);
    check("rerst seg",     {25'b0, bus.seg},     32'h40);
    check("rerst ans",     {24'b0, bus.ans},     32'hFE);
    wait_frame();
    check_frame(32'h0, 8'hFF);

`ifdef LEADING_ZERO_BLANK_EN
    strobe(32'h0000_00A5);
    wait_frame();
    check_frame(32'h0000_00A5, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
